// File: rtl/gpr_cdb_arbiter.sv
// gpr_cdb_arbiter
// Round-robin arbiter that owns the GPR common data bus. Grants at most one
// functional unit per cycle. It broadcasts that unit's registered result one
// cycle later, and keeps a saturating count of grants for debug and performance.
module gpr_cdb_arbiter #(
    parameter int N_UNIT    = 4,
    parameter int ROB_WIDTH = 6,   // keep in step with the ROB tag width used elsewhere
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [N_UNIT-1:0]           req_valid,
    output logic [N_UNIT-1:0]           req_ready,
    input  logic [N_UNIT*ROB_WIDTH-1:0] unit_tag,
    input  logic [N_UNIT*DATA_W-1:0]    unit_data,
    output logic                        cdb_valid,
    output logic [ROB_WIDTH-1:0]        cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [15:0]                 grant_count
);

    localparam int               IDX_W = $clog2(N_UNIT);
    localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N_UNIT);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_UNIT - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;

    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand_ext;
    logic [IDX_W-1:0] cand;

    // Grant search: first requester at or after rr_ptr, wrapping; blocked by reset/flush.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a value unassigned and no latch is inferred.
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand_ext  = '0;
        cand      = '0;
        if (!reset && !flush) begin
            for (int i = 0; i < N_UNIT; i++) begin
                cand_ext = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (cand_ext >= N_EXT) begin
                    cand_ext = cand_ext - N_EXT;
                end
                cand = cand_ext[IDX_W-1:0];
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer, pending-broadcast selection and grant counter; advance on each grant.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            rr_ptr      <= '0;
            sel_valid   <= 1'b0;
            sel_idx     <= '0;
            grant_count <= '0;
        end else if (grant_any) begin
            rr_ptr    <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            sel_valid <= 1'b1;
            sel_idx   <= grant_idx;
            if (grant_count != 16'hFFFF) begin
                grant_count <= grant_count + 16'd1;
            end
        end else begin
            sel_valid <= 1'b0;
        end
    end

    // Broadcast: mux the granted unit's registered result onto the bus.
    always_comb begin
        cdb_valid = sel_valid && !flush;
        cdb_tag   = '0;
        cdb_data  = '0;
        for (int j = 0; j < N_UNIT; j++) begin
            if (sel_idx == IDX_W'(j)) begin
                cdb_tag  = unit_tag[j*ROB_WIDTH +: ROB_WIDTH];
                cdb_data = unit_data[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// tb_gpr_cdb_arbiter
// Scoreboard bench: each grant pushes the winning unit index, and the broadcast
// one cycle later pops it and compares bus tag/data against that unit's values.
module tb_gpr_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 6;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] unit_tag;
    logic [N*DW-1:0] unit_data;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [15:0]     grant_count;

    logic [RW-1:0]   tag_v  [N];
    logic [DW-1:0]   data_v [N];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference model state
    int m_rr;
    bit m_sel;
    int m_cnt;
    int sb[$];

    gpr_cdb_arbiter #(.N_UNIT(N), .ROB_WIDTH(RW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .unit_tag(unit_tag), .unit_data(unit_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            unit_tag[j*RW +: RW] = tag_v[j];
            unit_data[j*DW +: DW] = data_v[j];
        end
    end

    task automatic set_units(input int base);
        for (int j = 0; j < N; j++) begin
            tag_v[j]  = RW'(base + j + 1);
            data_v[j] = DW'(32'hA000_0000 + base * 16 + j);
        end
    endtask

    task automatic model_reset();
        m_rr  = 0;
        m_sel = 0;
        m_cnt = 0;
        sb.delete();
    endtask

    // One cycle: drive at negedge, compare comb outputs mid-cycle, advance model.
    task automatic step(input logic [N-1:0] rv, input logic fl, input bit rnd,
                        output logic [N-1:0] got_ready);
        logic [N-1:0] exp_ready;
        int g;
        int k;
        int idx;
        @(negedge clk);
        req_valid = rv;
        flush     = fl;
        if (rnd) begin
            for (int j = 0; j < N; j++) begin
                tag_v[j]  = RW'($urandom);
                data_v[j] = $urandom;
            end
        end
        #1;
        exp_ready = '0;
        g = -1;
        if (!fl) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (g < 0 && rv[k]) g = k;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;

        total_cnt++;
        if (req_ready !== exp_ready)
            $display("FAIL req_ready: got %b expected %b (rv=%b flush=%b)", req_ready, exp_ready, rv, fl);
        else pass_cnt++;

        total_cnt++;
        if (cdb_valid !== (m_sel && !fl))
            $display("FAIL cdb_valid: got %b expected %b", cdb_valid, (m_sel && !fl));
        else pass_cnt++;

        if (m_sel) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL scoreboard: empty when broadcast expected");
            end else begin
                idx = sb.pop_front();
                if (!fl) begin
                    total_cnt++;
                    if (cdb_tag !== tag_v[idx] || cdb_data !== data_v[idx])
                        $display("FAIL cdb_payload: got tag %0d data %h expected unit %0d tag %0d data %h",
                                 cdb_tag, cdb_data, idx, tag_v[idx], data_v[idx]);
                    else pass_cnt++;
                end
            end
        end

        total_cnt++;
        if (grant_count !== 16'(m_cnt))
            $display("FAIL grant_count: got %0d expected %0d", grant_count, m_cnt);
        else pass_cnt++;

        got_ready = req_ready;

        if (g >= 0) begin
            sb.push_back(g);
            m_rr  = (g + 1) % N;
            m_sel = 1;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_sel = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '1;
        flush     = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [N-1:0] r;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b1111;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (cdb_valid !== 1'b0) $display("FAIL reset_cdb_valid: got %b expected 0", cdb_valid);
        else pass_cnt++;
        total_cnt++;
        if (grant_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", grant_count);
        else pass_cnt++;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        model_reset();

        // reset asserted mid-broadcast drops cdb_valid without waiting for a clock
        step(4'b0001, 1'b0, 1'b0, r);
        @(posedge clk);
        #2;
        req_valid = '0;
        total_cnt++;
        if (cdb_valid !== 1'b1) $display("FAIL pre_reset_broadcast: got %b expected 1", cdb_valid);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (cdb_valid !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL async_reset: got valid %b ready %b expected 0 / 0000", cdb_valid, req_ready);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_unit();
        logic [N-1:0] r;
        do_reset();
        set_units(0);
        tag_v[2]  = RW'(5);
        data_v[2] = 32'h0000_1234;
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 1'b0, 1'b0, r);
            total_cnt++;
            if (r !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", r);
            else pass_cnt++;
        end
        step(4'b0000, 1'b0, 1'b0, r);
        step(4'b0000, 1'b0, 1'b0, r);
    endtask

    task automatic test_all_requesting();
        logic [N-1:0] r;
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        set_units(10);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b0, 1'b0, r);
            total_cnt++;
            if (r !== exp_seq[c]) $display("FAIL rotation_%0d: got %b expected %b", c, r, exp_seq[c]);
            else pass_cnt++;
        end
        step(4'b0000, 1'b0, 1'b0, r);
    endtask

    task automatic test_wrap();
        logic [N-1:0] r;
        do_reset();
        set_units(20);
        step(4'b0100, 1'b0, 1'b0, r);   // pointer moves to 3
        step(4'b1001, 1'b0, 1'b0, r);
        total_cnt++;
        if (r !== 4'b1000) $display("FAIL wrap_first: got %b expected 1000", r);
        else pass_cnt++;
        step(4'b1001, 1'b0, 1'b0, r);
        total_cnt++;
        if (r !== 4'b0001) $display("FAIL wrap_second: got %b expected 0001", r);
        else pass_cnt++;
        step(4'b0000, 1'b0, 1'b0, r);
    endtask

    task automatic test_flush();
        logic [N-1:0] r;
        do_reset();
        set_units(30);
        step(4'b0010, 1'b0, 1'b0, r);
        step(4'b1111, 1'b1, 1'b0, r);
        total_cnt++;
        if (r !== 4'b0000 || cdb_valid !== 1'b0)
            $display("FAIL flush_cycle: got ready %b valid %b expected 0000 / 0", r, cdb_valid);
        else pass_cnt++;
        step(4'b1111, 1'b0, 1'b0, r);   // pointer left at 2 by the unit-1 grant
        total_cnt++;
        if (r !== 4'b0100) $display("FAIL flush_ptr: got %b expected 0100", r);
        else pass_cnt++;
        step(4'b0000, 1'b0, 1'b0, r);
    endtask

    task automatic test_back_to_back_random();
        logic [N-1:0] r;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step(N'($urandom), ($urandom_range(0, 9) == 0), 1'b1, r);
        end
        step(4'b0000, 1'b0, 1'b0, r);
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        repeat (65534) @(posedge clk);
        #1;
        total_cnt++;
        if (grant_count !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", grant_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (grant_count !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", grant_count);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (grant_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", grant_count);
        else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        set_units(0);
        model_reset();
        test_reset();
        test_single_unit();
        test_all_requesting();
        test_wrap();
        test_flush();
        test_back_to_back_random();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
